// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: adapts byte/half/word core loads and stores to a sync-read word RAM,
// with sign/zero extension on loads and read-modify-write for sub-word stores.
module data_mem_ctrl #(
    parameter int ADDR_W     = 10,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_ren,
    input  logic              core_wen,
    input  logic [1:0]        core_size,
    input  logic              core_sign,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdata,
    output logic [31:0]       core_rdata,
    output logic              core_stall,
    output logic              core_addr_err,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);
    typedef enum logic [1:0] {IDLE, LOAD, RMW} state_t;
    state_t state_q, state_d;
    logic is_byte, is_half, is_word, misalign, unused_addr;
    logic [1:0] lane_idx;
    logic [4:0] sh;
    logic [15:0] lane;
    logic [31:0] load_val, mask, ins, merged;

    assign ram_addr    = core_addr[ADDR_W+1:2];
    assign unused_addr = ^core_addr[31:ADDR_W+2];

    always_comb begin
        is_byte  = core_size == 2'b00;
        is_half  = core_size == 2'b01;
        is_word  = core_size[1];
        misalign = (is_half & core_addr[0]) | (is_word & |core_addr[1:0]);
        // big-endian lanes count down from the top: byte k -> lane 3-k, half at 0/2 -> lane 2/0
        lane_idx = !BIG_ENDIAN ? {core_addr[1], core_addr[0] & is_byte}
                 : is_byte ? ~core_addr[1:0] : {~core_addr[1], 1'b0};
        sh       = {lane_idx, 3'b000};
        lane     = 16'(ram_dout >> sh);
        load_val = is_byte ? {{24{core_sign & lane[7]}}, lane[7:0]}
                 : is_half ? {{16{core_sign & lane[15]}}, lane} : ram_dout;
        mask     = (is_byte ? 32'h0000_00ff : 32'h0000_ffff) << sh;
        ins      = (is_byte ? {24'b0, core_wdata[7:0]} : {16'b0, core_wdata[15:0]}) << sh;
        merged   = (ram_dout & ~mask) | ins;
        state_d       = state_q;
        ram_we        = 1'b0;
        ram_din       = 32'b0;
        core_stall    = 1'b0;
        core_addr_err = 1'b0;
        core_rdata    = 32'b0;
        unique case (state_q)
            IDLE: begin
                if ((core_wen | core_ren) & misalign) begin
                    core_addr_err = 1'b1;
                end else if (core_wen & is_word) begin
                    ram_we  = 1'b1;
                    ram_din = core_wdata;
                end else if (core_wen | core_ren) begin
                    core_stall = 1'b1;
                    state_d    = core_wen ? RMW : LOAD;
                end
            end
            LOAD: begin
                core_rdata = load_val;
                state_d    = IDLE;
            end
            RMW: begin
                ram_we  = 1'b1;
                ram_din = merged;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // outputs are forced quiet for the whole reset window, not just after the next edge
        if (!rst) begin
            ram_we        = 1'b0;
            ram_din       = 32'b0;
            core_stall    = 1'b0;
            core_addr_err = 1'b0;
            core_rdata    = 32'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed bench with a byte-addressed big-endian memory model and per-cycle output checks.
module tb_data_mem_ctrl;
    logic        clk, rst, core_ren, core_wen, core_sign;
    logic [1:0]  core_size;
    logic [31:0] core_addr, core_wdata, core_rdata, ram_din, ram_dout;
    logic        core_stall, core_addr_err, ram_we;
    logic [9:0]  ram_addr;

    data_mem_ctrl #(.ADDR_W(10), .BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .rst(rst), .core_ren(core_ren), .core_wen(core_wen), .core_size(core_size),
        .core_sign(core_sign), .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
        .core_stall(core_stall), .core_addr_err(core_addr_err), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int tests = 0, fails = 0;
    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endfunction

    logic [7:0] mb [0:4095];
    function automatic logic [31:0] mword(input int a);
        int b = a & ~3;
        return {mb[b], mb[b+1], mb[b+2], mb[b+3]};
    endfunction
    function automatic logic [31:0] mload(input int a, input logic [1:0] sz, input bit sg);
        logic [7:0] v = mb[a];
        logic [15:0] h = {mb[a], mb[a+1]};
        if (sz == 2'd0) return sg ? {{24{v[7]}}, v} : {24'b0, v};
        if (sz == 2'd1) return sg ? {{16{h[15]}}, h} : {16'b0, h};
        return mword(a);
    endfunction
    function automatic logic [31:0] mstored(input int a, input logic [1:0] sz, input logic [31:0] wd);
        logic [7:0] b [4];
        int o = a & 3;
        for (int i = 0; i < 4; i++) b[i] = mb[(a & ~3) + i];
        if (sz == 2'd0) b[o] = wd[7:0];
        else if (sz == 2'd1) begin b[o] = wd[15:8]; b[o+1] = wd[7:0]; end
        else for (int i = 0; i < 4; i++) b[i] = wd[31-8*i -: 8];
        return {b[0], b[1], b[2], b[3]};
    endfunction

    logic        e_stall, e_err, e_we;
    logic [31:0] e_din, e_rd;
    task automatic setx(input bit st, input bit er, input bit we, input logic [31:0] din, input logic [31:0] rd);
        e_stall = st; e_err = er; e_we = we; e_din = din; e_rd = rd;
    endtask

    logic [68:0] in_now, prev_in;
    logic        prev_st = 1'b0;
    assign in_now = {core_ren, core_wen, core_size, core_sign, core_addr, core_wdata};
    always @(negedge clk) begin
        chk("stall", {31'b0, core_stall}, {31'b0, e_stall});
        chk("addr_err", {31'b0, core_addr_err}, {31'b0, e_err});
        chk("ram_we", {31'b0, ram_we}, {31'b0, e_we});
        chk("rdata", core_rdata, e_rd);
        chk("ram_addr", {22'b0, ram_addr}, {22'b0, core_addr[11:2]});
        if (e_we) chk("ram_din", ram_din, e_din);
        if (rst && prev_st) chk("hold_inputs", {31'b0, in_now == prev_in}, 32'd1);
        prev_st <= core_stall;
        prev_in <= in_now;
    end

    task automatic drive(input bit w, input bit r, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd);
        core_wen = w; core_ren = r; core_size = sz; core_sign = sg; core_addr = a; core_wdata = wd;
    endtask

    task automatic idle();
        drive(0, 0, 2'd0, 0, 32'h0, 32'h0);
        setx(0, 0, 0, 0, 0);
        @(posedge clk); #1;
    endtask

    task automatic req(input bit w, input bit r, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                       input logic [31:0] wd, output int n, output logic [31:0] rd);
        int ba = int'(a[11:0]);
        bit mis = (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'b00);
        int en;
        bit st;
        logic [31:0] ld = mload(ba, sz, sg);
        logic [31:0] nw = mstored(ba, sz, wd);
        drive(w, r, sz, sg, a, wd);
        if (mis) begin en = 1; setx(0, 1, 0, 0, 0); end
        else if (w && sz[1]) begin en = 1; setx(0, 0, 1, wd, 0); end
        else begin en = 2; setx(1, 0, 0, 0, 0); end
        n = 0;
        do begin
            if (n == 1) begin
                if (w) setx(0, 0, 1, nw, 0);
                else setx(0, 0, 0, 0, ld);
            end
            @(negedge clk);
            n++;
            st = core_stall;
            rd = core_rdata;
            @(posedge clk); #1;
        end while (st && n < 4);
        chk("cycles", n, en);
        if (w && !mis) for (int i = 0; i < 4; i++) mb[(ba & ~3) + i] = nw[31-8*i -: 8];
        if (!mis) chk("ram_word", mem[ba[11:2]], mword(ba));
    endtask

    int n;
    logic [31:0] rd;
    initial begin
        for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
        rst = 1'b0;
        drive(1, 0, 2'd2, 0, 32'h10, 32'hDEADBEEF);
        setx(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        drive(0, 0, 2'd0, 0, 32'h0, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        req(1, 0, 2'd2, 0, 32'h10, 32'h11223344, n, rd);
        chk("t1_store_cyc", n, 1);
        req(0, 1, 2'd2, 0, 32'h10, 32'h0, n, rd);
        chk("t1_load_cyc", n, 2);
        chk("t1_load", rd, 32'h11223344);
        idle();

        req(1, 0, 2'd0, 0, 32'h11, 32'h000000AA, n, rd);
        chk("t2_cyc", n, 2);
        chk("t2_ram", mem[4], 32'h11AA3344);
        idle();

        req(1, 0, 2'd2, 0, 32'h10, 32'h80FF7F01, n, rd);
        req(0, 1, 2'd0, 1, 32'h10, 32'h0, n, rd); chk("t3_sb0", rd, 32'hFFFFFF80);
        req(0, 1, 2'd0, 0, 32'h11, 32'h0, n, rd); chk("t3_ub1", rd, 32'h000000FF);
        req(0, 1, 2'd1, 1, 32'h12, 32'h0, n, rd); chk("t3_sh2", rd, 32'h00007F01);
        req(0, 1, 2'd1, 1, 32'h10, 32'h0, n, rd); chk("t3_sh0", rd, 32'hFFFF80FF);
        req(0, 1, 2'd1, 0, 32'h10, 32'h0, n, rd); chk("t3_uh0", rd, 32'h000080FF);
        req(0, 1, 2'd0, 1, 32'h11, 32'h0, n, rd); chk("t3_sb1", rd, 32'hFFFFFFFF);
        req(0, 1, 2'd0, 1, 32'h13, 32'h0, n, rd); chk("t3_sb3", rd, 32'h00000001);
        req(0, 1, 2'd3, 0, 32'h10, 32'h0, n, rd); chk("t3_size3", rd, 32'h80FF7F01);
        idle();

        req(1, 0, 2'd1, 0, 32'h13, 32'h0000BEEF, n, rd); chk("t4_h_cyc", n, 1);
        req(0, 1, 2'd2, 0, 32'h16, 32'h0, n, rd);        chk("t4_w_cyc", n, 1);
        chk("t4_w_rd", rd, 32'h0);
        req(0, 1, 2'd3, 1, 32'h11, 32'h0, n, rd);        chk("t4_s3_cyc", n, 1);
        chk("t4_ram", mem[4], 32'h80FF7F01);
        req(1, 0, 2'd1, 0, 32'h12, 32'h1234BEEF, n, rd);
        chk("t4_half_store", mem[4], 32'h80FFBEEF);
        idle();

        req(1, 0, 2'd2, 0, 32'h20, 32'hCAFEBABE, n, rd); chk("t5_c1", n, 1);
        req(0, 1, 2'd0, 0, 32'h21, 32'h0, n, rd);        chk("t5_c2", n, 2);
        chk("t5_rd_byte", rd, 32'h000000FE);
        req(1, 0, 2'd0, 0, 32'h23, 32'h0000005A, n, rd); chk("t5_c3", n, 2);
        req(0, 1, 2'd2, 0, 32'h20, 32'h0, n, rd);        chk("t5_c4", n, 2);
        chk("t5_rd_word", rd, 32'hCAFEBA5A);
        idle();

        req(1, 0, 2'd2, 0, 32'h30, 32'h01020304, n, rd);
        drive(1, 0, 2'd0, 0, 32'h31, 32'h00000099);
        setx(1, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        setx(0, 0, 0, 0, 0);
        #1;
        chk("t6_we_drop", {31'b0, ram_we}, 32'd0);
        @(posedge clk); #1;
        drive(0, 0, 2'd0, 0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        chk("t6_ram", mem[12], 32'h01020304);
        req(0, 1, 2'd2, 0, 32'h30, 32'h0, n, rd);
        chk("t6_load", rd, 32'h01020304);
        req(0, 1, 2'd0, 0, 32'h31, 32'h0, n, rd);
        chk("t6_byte", rd, 32'h00000002);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Sits between mips_core's memory port and data_ram.
- Converts core load/store requests of byte, halfword or word size into word-wide accesses on the synchronous-read single-port RAM.
- Performs sign/zero extension on loads and read-modify-write (RMW) for sub-word stores.
- Stalls the core while a multi-cycle access is in flight.

Parameters:
ADDR_W, 10, RAM word-address width; RAM depth = 2^ADDR_W words
BIG_ENDIAN, 1, 1: byte offset 0 maps to bits [31:24]; 0: byte offset 0 maps to bits [7:0]

Ports:
clk  input  1  main clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
core_ren  input  1  load request
core_wen  input  1  store request; priority over core_ren if both are high
core_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
core_sign  input  1  loads only: 1 = sign-extend, 0 = zero-extend
core_addr  input  32  byte address
core_wdata  input  32  store data, right-justified for sub-word sizes
core_rdata  output  32  load result; valid in the load completion cycle
core_stall  output  1  core must hold all request inputs stable while high
core_addr_err  output  1  misaligned access flag; single cycle
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_W  RAM word address = core_addr[ADDR_W+1:2]
ram_din  output  32  RAM write data
ram_dout  input  32  RAM read data; one-cycle latency after ram_addr

Behaviour:
- States: IDLE, LOAD, RMW. Reset (rst=0) forces IDLE immediately.
- While in reset, ram_we=0, core_stall=0, core_addr_err=0 and core_rdata=0, independent of clk.
- ram_addr always follows core_addr combinationally. Core address bits above ADDR_W+1 are ignored.
- Misalignment is checked in IDLE: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Sets core_addr_err=1 for that cycle only.
  - No RAM write, core_stall=0, core_rdata=0, state stays IDLE.
- Word store, IDLE: ram_we=1, ram_din=core_wdata, core_stall=0. Single cycle; state stays IDLE.
- Load, IDLE: core_stall=1, next state LOAD.
- LOAD:
  - core_stall=0.
  - core_rdata = lane of ram_dout selected by addr[1:0] and size, extended per core_sign.
  - Next state IDLE. Total latency is 2 cycles (1 stall cycle).
- Sub-word store, IDLE: ram_we=0, core_stall=1, next state RMW.
- RMW:
  - ram_we=1; ram_din = ram_dout with the addressed byte/half lane replaced by core_wdata[7:0] or [15:0].
  - core_stall=0; next state IDLE. Total 2 cycles.
- Lane mapping with BIG_ENDIAN=1:
  - Byte offset k occupies bits [31-8k -: 8].
  - Half at offset 0 occupies [31:16]; half at offset 2 occupies [15:0].
- Size 11 and size 10 behave identically.
- No request (ren=wen=0) in IDLE: all outputs 0, state holds.
- Back-to-back requests: a new request may be presented in the cycle after completion and is accepted in IDLE with no bubble.
- core_rdata is 0 in every cycle other than LOAD.
- Request inputs changing while core_stall=1 is a protocol violation. The bench asserts against it; the RTL result is undefined.
- Reset asserted in LOAD or RMW:
  - Access is abandoned and no partial write occurs.
  - After reset is released, the block resumes in IDLE.

Test Plan:
1. Store word 0x11223344 @0x10, then load word @0x10 -> ram_we pulse at word 4 with no stall; load has 1 stall cycle and core_rdata=0x11223344.
2. RAM[4]=0x11223344; store byte 0xAA @0x11 -> RMW takes 2 cycles (stall 1 then 0); RAM[4]=0x11AA3344.
3. RAM[4]=0x80FF7F01; load byte signed @0x10 -> 0xFFFFFF80. Unsigned @0x11 -> 0x000000FF. Signed half @0x12 -> 0x00007F01.
4. Store half 0xBEEF @0x13, then load word @0x16 -> core_addr_err=1 for each, no ram_we, no stall, core_rdata=0, RAM unchanged.
5. Sequence word store, byte load, byte store, word load issued back-to-back -> cycle counts 1, 2, 2, 2; correct data returned; no bubbles between requests.
6. Assert rst low during the RMW cycle of a byte store -> ram_we drops immediately, RAM word unchanged, state IDLE; next load returns the old value.
